// File: rtl/bus8085_pkg.sv
// Shared types and constants for the 8085 bus responder.
//   state_e      : responder cycle-tracking states
//   CYC_*        : S1/S0 status encodings latched at ALE
//   addr_select  : decides whether a cycle latched at ALE targets this slave
package bus8085_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_WR_HOLD = 3'd5,
    ST_DRAIN   = 3'd6
  } state_e;

  localparam logic [1:0] CYC_HALT  = 2'b00;
  localparam logic [1:0] CYC_WRITE = 2'b01;
  localparam logic [1:0] CYC_READ  = 2'b10;
  localparam logic [1:0] CYC_FETCH = 2'b11;

  // Halt cycles never select; IO cycles select only when IO decoding is enabled.
  function automatic logic addr_select(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] mask,
                                       input logic [1:0]  cyc,
                                       input logic        io,
                                       input logic        io_en);
    return ((addr & mask) == base) && (cyc != CYC_HALT) && (io_en || !io);
  endfunction

endpackage

// File: rtl/bus8085_wait_ctr.sv
// Wait-state counter for the bus responder.
//   clk, rst : clock and asynchronous active-high reset
//   load     : load WAIT_STATES (takes priority over dec)
//   dec      : decrement, saturating at zero
//   zero     : counter currently holds zero
module bus8085_wait_ctr #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(WAIT_STATES);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus8085_responder.sv
// Slave endpoint of the 8085 multiplexed bus.
// Latches the address/status at ALE, turns RD#/WR# strobes into single-cycle
// requests to a backing store, holds READY low until both the minimum wait
// count has elapsed and the store has answered, then drives read data on AD.
//   phi1, reset          : clock, asynchronous active-high reset
//   ale, ad_in, a_hi     : address latch enable, AD7..0 (addr / wdata), A15..8
//   rd_n, wr_n           : active-low strobes
//   io_m_n, s1, s0       : cycle qualification
//   ad_out, ad_oe, ready : read data, AD drive enable, READY to CPU
//   req_*                : backing-store request (pulse, space, address, data)
//   rsp_valid, rsp_rdata : backing-store completion
//   cyc_type             : {s1,s0} latched at ALE
//   bus_err              : single-cycle protocol error pulse
module bus8085_responder
  import bus8085_pkg::*;
#(
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [15:0] ADDR_MASK   = 16'h0000,
  parameter logic        IO_EN       = 1'b1
) (
  input  logic        phi1,
  input  logic        reset,
  input  logic        ale,
  input  logic [7:0]  ad_in,
  input  logic [7:0]  a_hi,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        io_m_n,
  input  logic        s1,
  input  logic        s0,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  output logic        ready,
  output logic        req_rd,
  output logic        req_wr,
  output logic        req_io,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  output logic [1:0]  cyc_type,
  output logic        bus_err
);

  state_e      state_q,     state_d;
  logic        ready_q,     ready_d;
  logic        ad_oe_q,     ad_oe_d;
  logic [7:0]  ad_out_q,    ad_out_d;
  logic        req_rd_q,    req_rd_d;
  logic        req_wr_q,    req_wr_d;
  logic        req_io_q,    req_io_d;
  logic [15:0] req_addr_q,  req_addr_d;
  logic [7:0]  req_wdata_q, req_wdata_d;
  logic [1:0]  cyc_type_q,  cyc_type_d;
  logic        bus_err_q,   bus_err_d;
  logic        rsp_seen_q,  rsp_seen_d;
  logic [7:0]  rdata_q,     rdata_d;

  logic ctr_load;
  logic ctr_dec;
  logic cnt_zero;
  logic sel;
  logic rsp_any;

  bus8085_wait_ctr #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctr (
    .clk  (phi1),
    .rst  (reset),
    .load (ctr_load),
    .dec  (ctr_dec),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    ad_oe_d     = ad_oe_q;
    ad_out_d    = ad_out_q;
    req_rd_d    = 1'b0;
    req_wr_d    = 1'b0;
    req_io_d    = req_io_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    cyc_type_d  = cyc_type_q;
    bus_err_d   = 1'b0;
    rsp_seen_d  = rsp_seen_q;
    rdata_d     = rdata_q;
    ctr_load    = 1'b0;
    ctr_dec     = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);
    sel         = addr_select({a_hi, ad_in}, BASE_ADDR, ADDR_MASK, {s1, s0}, io_m_n, IO_EN);
    // A response may have been captured earlier or may be arriving right now.
    rsp_any     = rsp_seen_q | rsp_valid;

    if (!rd_n && !wr_n) begin
      // Both strobes low is illegal in every state: abandon whatever was in flight.
      bus_err_d = 1'b1;
      state_d   = ST_IDLE;
      ad_oe_d   = 1'b0;
      ready_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_ARMED: begin
          if (ale) begin
            // Latched state only changes for cycles that target us, so
            // req_addr keeps the last served address across foreign cycles.
            if (sel) begin
              req_addr_d = {a_hi, ad_in};
              req_io_d   = io_m_n;
              cyc_type_d = {s1, s0};
              state_d    = ST_ARMED;
            end else begin
              state_d    = ST_IDLE;
            end
          end else if ((state_q == ST_ARMED) && !rd_n) begin
            req_rd_d   = 1'b1;
            ready_d    = 1'b0;
            ctr_load   = 1'b1;
            rsp_seen_d = 1'b0;
            state_d    = ST_RD_WAIT;
          end else if ((state_q == ST_ARMED) && !wr_n) begin
            req_wdata_d = ad_in;
            req_wr_d    = 1'b1;
            ready_d     = 1'b0;
            ctr_load    = 1'b1;
            rsp_seen_d  = 1'b0;
            state_d     = ST_WR_WAIT;
          end
        end

        ST_RD_WAIT, ST_WR_WAIT: begin
          if (rsp_valid && !rsp_seen_q) begin
            rsp_seen_d = 1'b1;
            rdata_d    = rsp_rdata;
          end
          if ((state_q == ST_RD_WAIT) ? rd_n : wr_n) begin
            // CPU gave up on the cycle. If the store already answered there is
            // nothing left to swallow; otherwise drain its late response.
            ready_d = 1'b1;
            ad_oe_d = 1'b0;
            state_d = rsp_any ? ST_IDLE : ST_DRAIN;
          end else if (cnt_zero && rsp_any) begin
            ready_d = 1'b1;
            if (state_q == ST_RD_WAIT) begin
              ad_out_d = rsp_seen_q ? rdata_q : rsp_rdata;
              ad_oe_d  = 1'b1;
              state_d  = ST_RD_HOLD;
            end else begin
              state_d  = ST_WR_HOLD;
            end
          end
        end

        ST_RD_HOLD: begin
          if (rd_n) begin
            ad_oe_d = 1'b0;
            state_d = ST_IDLE;
          end
        end

        ST_WR_HOLD: begin
          if (wr_n) begin
            state_d = ST_IDLE;
          end
        end

        ST_DRAIN: begin
          // A new cycle cannot start while the store still owes a response.
          if (ale) begin
            bus_err_d = 1'b1;
          end
          if (rsp_valid) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_io_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      cyc_type_q  <= '0;
      bus_err_q   <= 1'b0;
      rsp_seen_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      req_io_q    <= req_io_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      cyc_type_q  <= cyc_type_d;
      bus_err_q   <= bus_err_d;
      rsp_seen_q  <= rsp_seen_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ad_out    = ad_out_q;
  assign ad_oe     = ad_oe_q;
  assign ready     = ready_q;
  assign req_rd    = req_rd_q;
  assign req_wr    = req_wr_q;
  assign req_io    = req_io_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign cyc_type  = cyc_type_q;
  assign bus_err   = bus_err_q;

endmodule
